// File: rtl/mux8x1_rr_arbiter_if.sv
// Request/grant/select bundle between eight requesters, the round-robin arbiter
// and the 8:1 mux it steers.
interface mux8x1_rr_arbiter_if;
  logic [7:0] Req;
  logic [7:0] Gnt;
  logic       Sel0;
  logic       Sel1;
  logic       Sel2;
  logic       Busy;

  // Arbiter side: consumes requests, drives grant and mux selects.
  modport master (
    input  Req,
    output Gnt,
    output Sel0,
    output Sel1,
    output Sel2,
    output Busy
  );

  // Requester/mux side.
  modport slave (
    output Req,
    input  Gnt,
    input  Sel0,
    input  Sel1,
    input  Sel2,
    input  Busy
  );
endinterface

// File: rtl/mux8x1_rr_arbiter.sv
// Round-robin arbiter owning the select lines of an 8:1 mux, with a bounded
// hold time that only forces a release when another requester is waiting.
module mux8x1_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  mux8x1_rr_arbiter_if.master  arb
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_reg;
  logic [2:0]       ptr_reg;
  logic [2:0]       owner_reg;
  logic [2:0]       sel_reg;
  logic [7:0]       gnt_reg;
  logic             busy_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [7:0]       req_rot;
  logic [2:0]       win_off;
  logic [2:0]       winner;
  logic             req_any;
  logic             owner_req;
  logic             others_pending;
  logic             hold_done;

  // Rotate the request vector so bit 0 is the current highest-priority index.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      logic [2:0] idx;
      assign idx         = ptr_reg + 3'(gi);
      assign req_rot[gi] = arb.Req[idx];
    end
  endgenerate

  always_comb begin
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = 3'(i);
      end
    end
  end

  assign winner         = ptr_reg + win_off;
  assign req_any        = |arb.Req;
  assign owner_req      = arb.Req[owner_reg];
  assign others_pending = |(arb.Req & ~(8'b1 << owner_reg));
  assign hold_done      = (cnt_reg == CNT_LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 3'd0;
      owner_reg <= 3'd0;
      sel_reg   <= 3'd0;
      gnt_reg   <= 8'h00;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_any) begin
            gnt_reg   <= 8'b1 << winner;
            sel_reg   <= winner;
            owner_reg <= winner;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          // Release and preemption share one exit; select lines stay put so
          // the mux output does not glitch during the turnaround cycle.
          if (!owner_req || (hold_done && others_pending)) begin
            gnt_reg   <= 8'h00;
            busy_reg  <= 1'b0;
            ptr_reg   <= owner_reg + 3'd1;
            state_reg <= IDLE;
          end else if (hold_done) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 8'h00;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign arb.Gnt  = gnt_reg;
  assign arb.Sel0 = sel_reg[0];
  assign arb.Sel1 = sel_reg[1];
  assign arb.Sel2 = sel_reg[2];
  assign arb.Busy = busy_reg;

endmodule

// File: tb/tb_mux8x1_rr_arbiter.sv
// Directed bench for mux8x1_rr_arbiter (MAX_HOLD=4): a cycle table for reset,
// single-requester and wrap-around ordering, then hand sequences for hold limits.
module tb_mux8x1_rr_arbiter;

  logic Clk;
  logic Rst;

  mux8x1_rr_arbiter_if bus ();

  mux8x1_rr_arbiter #(.MAX_HOLD(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .arb (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
  } vec_t;

  vec_t tbl [17];
  int   vectors;
  int   miscompares;

  // Drive one cycle of inputs, let one edge pass, then compare outputs.
  task automatic step(input string name, input logic rst_i, input logic [7:0] req_i,
                      input logic [7:0] g, input logic [2:0] s, input logic b);
    logic [2:0] sel_now;
    Rst     = rst_i;
    bus.Req = req_i;
    @(posedge Clk);
    #1;
    sel_now = {bus.Sel2, bus.Sel1, bus.Sel0};
    vectors++;
    if (bus.Gnt !== g || sel_now !== s || bus.Busy !== b) begin
      miscompares++;
      $display("FAIL %s #%0d: got Gnt=%h Sel=%0d Busy=%b, want Gnt=%h Sel=%0d Busy=%b",
               name, vectors, bus.Gnt, sel_now, bus.Busy, g, s, b);
    end else begin
      $display("%s #%0d: rst=%b req=%h -> Gnt=%h Sel=%0d Busy=%b",
               name, vectors, rst_i, req_i, bus.Gnt, sel_now, bus.Busy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Rst         = 1'b1;
    bus.Req     = 8'hFF;

    // reset held two cycles, first grant from Ptr=0
    tbl[0]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0};
    tbl[2]  = '{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
    // single requester 5, held across a no-contention hold wrap
    tbl[4]  = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1};
    tbl[5]  = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1};
    tbl[6]  = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1};
    tbl[7]  = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1};
    tbl[8]  = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 8'h00, 3'd5, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 8'h00, 3'd5, 1'b0};
    // Ptr=6, requesters 6,7,0 each release after one cycle
    tbl[11] = '{1'b0, 8'hC1, 8'h40, 3'd6, 1'b1};
    tbl[12] = '{1'b0, 8'h81, 8'h00, 3'd6, 1'b0};
    tbl[13] = '{1'b0, 8'h81, 8'h80, 3'd7, 1'b1};
    tbl[14] = '{1'b0, 8'h01, 8'h00, 3'd7, 1'b0};
    tbl[15] = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      step("table", tbl[i].rst, tbl[i].req, tbl[i].gnt, tbl[i].sel, tbl[i].busy);
    end

    // Preemption from Ptr=1: owner 2 capped at 4 cycles once 3 is waiting
    step("preempt", 1'b0, 8'h04, 8'h04, 3'd2, 1'b1);
    step("preempt", 1'b0, 8'h04, 8'h04, 3'd2, 1'b1);
    step("preempt", 1'b0, 8'h0C, 8'h04, 3'd2, 1'b1);
    step("preempt", 1'b0, 8'h0C, 8'h04, 3'd2, 1'b1);
    step("preempt", 1'b0, 8'h0C, 8'h00, 3'd2, 1'b0);
    step("preempt", 1'b0, 8'h0C, 8'h08, 3'd3, 1'b1);
    step("preempt", 1'b0, 8'h04, 8'h00, 3'd3, 1'b0);
    // Ptr=4 now: the preempted requester 2 is served on the wrap
    step("preempt", 1'b0, 8'h04, 8'h04, 3'd2, 1'b1);
    step("preempt", 1'b0, 8'h00, 8'h00, 3'd2, 1'b0);

    // Lone requester 1 keeps the mux well past MAX_HOLD
    for (int i = 0; i < 12; i++) begin
      step("hold", 1'b0, 8'h02, 8'h02, 3'd1, 1'b1);
    end
    step("hold", 1'b0, 8'h00, 8'h00, 3'd1, 1'b0);

    // Reset during a grant to requester 4 (Ptr=2 beforehand)
    step("rst_mid", 1'b0, 8'h10, 8'h10, 3'd4, 1'b1);
    step("rst_mid", 1'b1, 8'h11, 8'h00, 3'd0, 1'b0);
    step("rst_mid", 1'b0, 8'h11, 8'h01, 3'd0, 1'b1);
    step("rst_mid", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux8x1_rr_arbiter.md
Name: mux8x1_rr_arbiter

Overview:
Round-robin arbiter that shares one 8:1 multiplexer among eight requesters. It grants the mux to one requester at a time, drives the mux select lines Sel2/Sel1/Sel0 with the owner's index, and enforces a bounded hold time so no requester can starve the others. It sits directly in front of mux_8x1 and is the only driver of its select inputs.

Parameters:
MAX_HOLD, 16, maximum consecutive GRANT cycles for one owner while another requester is pending; legal range 2..256; hold counter width is clog2(MAX_HOLD).

Ports:
Clk  input  1  system clock; all logic on the rising edge
Rst  input  1  synchronous, active-high reset
Req  input  8  request vector; Req[i] high means requester i wants the mux (level, held for the whole transfer)
Gnt  output 8  one-hot grant vector; all zero when no owner; registered
Sel0 output 1  mux select bit 0 (owner index bit 0); registered
Sel1 output 1  mux select bit 1; registered
Sel2 output 1  mux select bit 2; registered
Busy output 1  high while in GRANT; registered

Behaviour:
- One clock and one reset. Reset is synchronous and active-high; it overrides every other condition on the same edge.
- Reset values: Gnt=8'h00, {Sel2,Sel1,Sel0}=3'd0, Busy=0, state=IDLE, Ptr=3'd0, Cnt=0.
- Internal state:
  - FSM states IDLE and GRANT.
  - Ptr (3 bits): highest-priority index for the next search.
  - Owner (3 bits): index of the current owner.
  - Cnt: hold counter.
- IDLE, Req==0: stay in IDLE; all outputs hold their values (Gnt=0, Busy=0, Sel unchanged).
- IDLE, Req!=0:
  - Winner = first i with Req[i]=1, searching Ptr, Ptr+1, ... mod 8 (wraps 7 to 0).
  - On that edge: Gnt <= one-hot(winner), {Sel2,Sel1,Sel0} <= winner, Owner <= winner, Busy <= 1, Cnt <= 0, go to GRANT.
  - Latency: Req sampled high at edge k gives Gnt visible after edge k.
- GRANT, evaluated each edge in this priority order:
  1. Req[Owner]==0 (voluntary release): Gnt <= 0, Busy <= 0, Ptr <= Owner+1 mod 8, go to IDLE.
  2. Cnt==MAX_HOLD-1 and (Req with bit Owner masked)!=0 (preemption): same actions as release.
  3. Cnt==MAX_HOLD-1 with no other requester: remain in GRANT, Cnt <= 0.
  4. Otherwise: Cnt <= Cnt+1.
- Select lines are never changed in GRANT. They keep their last value in IDLE, so the mux output does not glitch between grants.
- Back-to-back grants always have exactly one IDLE cycle with Gnt=0 (turnaround). A preempted owner that keeps Req high competes again from Ptr=Owner+1, so it is served last among the current requesters.
- A Req change in the same cycle as a grant decision is not seen until the next edge (Req is sampled only at edges).
- Rst asserted during GRANT: outputs return to reset values after that edge. No partial release; Ptr returns to 0.
- Gnt is one-hot or zero at all times. Busy equals (Gnt!=0). {Sel2,Sel1,Sel0} equals the index of the Gnt bit whenever Gnt!=0.

Test Plan:
- Reset: hold Rst high 2 cycles with Req=8'hFF -> Gnt=00, Sel=0, Busy=0. Release Rst -> next edge Gnt=8'h01, Sel=0, Busy=1.
- Single requester: Req=8'h20 for 5 cycles, then 00 -> Gnt=8'h20, Sel=3'd5 for 5 cycles. Gnt=00 on the cycle after Req drops; Sel stays 5; Ptr=6.
- Round robin with wrap: Ptr=6, Req=8'hC1, each owner releases after 1 cycle -> grant order 6, 7, 0, each separated by one Gnt=00 cycle.
- Preemption: MAX_HOLD=4, Req[2] held high, Req[3] raised at grant cycle 1 -> Gnt=8'h04 for exactly 4 cycles, one Gnt=00 cycle, then Gnt=8'h08, Sel=3.
- No-contention hold: MAX_HOLD=4, only Req[1] high for 12 cycles -> Gnt=8'h02 continuously for 12 cycles, no release.
- Reset mid-grant: Gnt=8'h10 active, Rst pulsed 1 cycle with Req=8'h11 held -> Gnt=00 after the reset edge, then Gnt=8'h01 (Ptr=0), Sel=0.
